// File: rtl/nr_pkg.sv
// ---------------------------------------------------------------------------
// nr_pkg
// Shared types and constants for the Newton-Raphson reciprocal controller.
//   W           : datapath width of the Q1.11 estimate and the Q0.12 divisor
//   q111_t      : unsigned Q1.11 value
//   nr_state_t  : controller states
//   TWO_Q111    : 2.0 in Q1.11 (needs 13 bits)
//   SAT_Q111    : largest representable Q1.11 value
//   X0_DEFAULT  : default seed estimate (1.5)
// ---------------------------------------------------------------------------
package nr_pkg;

   localparam int W = 12;

   typedef logic [W-1:0] q111_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP_A = 2'd1,
      STEP_B = 2'd2,
      DONE   = 2'd3
   } nr_state_t;

   localparam logic [12:0] TWO_Q111   = 13'h1000;
   localparam q111_t       SAT_Q111   = 12'hFFF;
   localparam q111_t       X0_DEFAULT = 12'hC00;

endpackage

// File: rtl/mul12.sv
// ---------------------------------------------------------------------------
// mul12
// Combinational 12x12 -> 24 unsigned multiplier.
//   i_a, i_b : 12-bit unsigned operands
//   o_p      : full 24-bit product
// ---------------------------------------------------------------------------
module mul12 (
   input  logic [11:0] i_a,
   input  logic [11:0] i_b,
   output logic [23:0] o_p
);

   assign o_p = {12'h000, i_a} * {12'h000, i_b};

endmodule

// File: rtl/nr_recip_ctrl.sv
// ---------------------------------------------------------------------------
// nr_recip_ctrl
// Reciprocal of a normalized 12-bit divisor by Newton-Raphson iteration
// x(k+1) = x(k) * (2 - D*x(k)), using one shared mul12 over two cycles
// per iteration.
//   i_clk     : system clock, rising edge
//   i_rst_n   : synchronous reset, active-low
//   i_start   : request pulse, only honoured in IDLE
//   i_divisor : D, unsigned Q0.12, must have bit 11 set
//   o_busy    : high while iterating
//   o_done    : one-cycle pulse, o_recip/o_err valid
//   o_err     : divisor was not normalized
//   o_recip   : 1/D in unsigned Q1.11, held until the next result
// ---------------------------------------------------------------------------
module nr_recip_ctrl
   import nr_pkg::*;
#(
   parameter int    ITERS = 4,
   parameter q111_t X0    = X0_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic [W-1:0]  i_divisor,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [W-1:0]  o_recip
);

   localparam logic [3:0] LAST_CNT = 4'(ITERS - 1);

   nr_state_t   r_state;
   q111_t       r_d;
   q111_t       r_x;
   q111_t       r_e;
   logic [3:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   q111_t       r_recip;

   nr_state_t   w_state_nxt;
   q111_t       w_d_nxt;
   q111_t       w_x_nxt;
   q111_t       w_e_nxt;
   logic [3:0]  w_cnt_nxt;
   logic        w_err_nxt;

   q111_t       w_mul_a;
   q111_t       w_mul_b;
   logic [23:0] w_p;

   q111_t       w_t;
   logic [12:0] w_e_full;
   q111_t       w_e_sat;
   logic [23:0] w_q_shr;
   q111_t       w_x_sat;

   mul12 u_mul12 (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_p)
   );

   // STEP_A: T = D*x truncated to Q1.11; e = 2 - T, which only overflows
   // 12 bits when T is zero, so that single case saturates.
   assign w_t      = w_p[23:12];
   assign w_e_full = TWO_Q111 - {1'b0, w_t};
   assign w_e_sat  = (w_e_full > {1'b0, SAT_Q111}) ? SAT_Q111 : w_e_full[11:0];

   // STEP_B: Q2.22 product back to Q1.11; anything >= 2.0 clips to all-ones.
   assign w_q_shr  = w_p >> 5'd11;
   assign w_x_sat  = (w_q_shr > {12'h000, SAT_Q111}) ? SAT_Q111 : w_q_shr[11:0];

   // Next-state, operand mux and datapath register updates.
   always_comb begin
      w_state_nxt = r_state;
      w_d_nxt     = r_d;
      w_x_nxt     = r_x;
      w_e_nxt     = r_e;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_mul_a     = 12'h000;
      w_mul_b     = 12'h000;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_d_nxt   = i_divisor;
               w_cnt_nxt = 4'd0;
               if (i_divisor[11]) begin
                  w_x_nxt     = X0;
                  w_err_nxt   = 1'b0;
                  w_state_nxt = STEP_A;
               end else begin
                  w_x_nxt     = 12'h000;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = DONE;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         STEP_A: begin
            w_mul_a     = r_d;
            w_mul_b     = r_x;
            w_e_nxt     = w_e_sat;
            w_state_nxt = STEP_B;
         end
         STEP_B: begin
            w_mul_a   = r_x;
            w_mul_b   = r_e;
            w_x_nxt   = w_x_sat;
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == LAST_CNT) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = STEP_A;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; outputs follow the next state
   // so they line up with the cycle the FSM is in.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_d     <= 12'h000;
         r_x     <= 12'h000;
         r_e     <= 12'h000;
         r_cnt   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_recip <= 12'h000;
      end else begin
         r_state <= w_state_nxt;
         r_d     <= w_d_nxt;
         r_x     <= w_x_nxt;
         r_e     <= w_e_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == STEP_A) || (w_state_nxt == STEP_B);
         r_done  <= (w_state_nxt == DONE);
         r_err   <= w_err_nxt;
         // x is forced to zero on the error path, so this also gives recip=0.
         if (w_state_nxt == DONE) begin
            r_recip <= w_x_nxt;
         end else begin
            r_recip <= r_recip;
         end
      end
   end

   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_err   = r_err;
   assign o_recip = r_recip;

endmodule
